// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
//   Time-multiplexes a latched 32-bit word as eight hex digits onto a shared
//   7-segment bus (digit select active-low, segments {dp,g,f,e,d,c,b,a}).
//   New words are staged in a pending register and promoted to the display
//   register only at frame boundaries, so a frame never mixes two words.
//   Each digit slot starts with a short blanking window to suppress ghosting.
//
//   Optional feature (macro FND_LZB_EN): leading-zero blanking. When defined,
//   digits above the highest nonzero nibble are kept dark unless their
//   decimal point is set; digit 0 is always shown. When undefined, all eight
//   digits are scanned and no mask logic exists.
module fnd_scan_driver #(
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        data_valid,
  input  logic        blank,
  output logic [7:0]  digit,
  output logic [7:0]  fnd,
  output logic        frame_done
);

  // Slot counter width; SCAN_DIV >= 2 so this is always at least 1.
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0] TC_VAL     = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_TC_VAL = CNT_W'(SCAN_DIV - 2);
  localparam logic [CNT_W-1:0] BLANK_VAL  = CNT_W'(BLANK_CYC);

  // Segment bus value that lights nothing, for either polarity.
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // Hex nibble to active-high gfedcba pattern.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Map an active-high {dp,gfedcba} pattern onto the board's segment polarity.
  function automatic logic [7:0] seg_polarity(input logic [7:0] seg_hi);
    return (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
  endfunction

  // Scan state
  logic [CNT_W-1:0] r_div_cnt;
  logic [2:0]       r_idx;

  // Displayed and pending words
  logic [31:0]      r_disp_data;
  logic [7:0]       r_disp_dp;
  logic [31:0]      r_pend_data;
  logic [7:0]       r_pend_dp;
  logic             r_pend_flag;

  // Registered outputs
  logic [7:0]       r_digit;
  logic [7:0]       r_fnd;
  logic             r_frame_done;

  // Combinational helpers
  logic             w_tc;
  logic             w_frame_bnd;
  logic             w_pre_bnd;
  logic             w_in_blank_win;
  logic [3:0]       w_nibble;
  logic             w_dp_bit;
  logic [7:0]       w_show_mask;
  logic [7:0]       w_digit_nxt;
  logic [7:0]       w_fnd_nxt;

  assign w_tc           = (r_div_cnt == TC_VAL);
  assign w_frame_bnd    = w_tc && (r_idx == 3'd7);
  assign w_pre_bnd      = (r_div_cnt == PRE_TC_VAL) && (r_idx == 3'd7);
  assign w_in_blank_win = (r_div_cnt < BLANK_VAL);
  assign w_nibble       = r_disp_data[{r_idx, 2'b00} +: 4];
  assign w_dp_bit       = r_disp_dp[r_idx];

`ifdef FND_LZB_EN
  // Leading-zero mask: walk from the top nibble down, a digit is shown once any
  // nibble at or above it is nonzero, or if its dp is lit; digit 0 always shows.
  always_comb begin
    logic w_seen_nz;
    w_show_mask = 8'h00;
    w_seen_nz   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      w_seen_nz      = w_seen_nz | (r_disp_data[4*i +: 4] != 4'h0);
      w_show_mask[i] = w_seen_nz | r_disp_dp[i] | (i == 0);
    end
  end
`else
  assign w_show_mask = 8'hFF;
`endif

  // Slot divider and digit index; idx steps at terminal count and wraps 7 -> 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_idx     <= 3'd0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_idx     <= r_idx + 3'd1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Load path: stage strobed words, promote at frame boundary; a strobe that
  // lands on the boundary itself goes straight to the display (newest wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
      r_disp_data <= '0;
      r_disp_dp   <= '0;
    end else begin
      if (data_valid) begin
        r_pend_data <= data_in;
        r_pend_dp   <= dp_in;
      end
      if (w_frame_bnd) begin
        r_pend_flag <= 1'b0;
        if (data_valid) begin
          r_disp_data <= data_in;
          r_disp_dp   <= dp_in;
        end else if (r_pend_flag) begin
          r_disp_data <= r_pend_data;
          r_disp_dp   <= r_pend_dp;
        end
      end else if (data_valid) begin
        r_pend_flag <= 1'b1;
      end
    end
  end

  // Next digit/segment drive for the current scan position.
  always_comb begin
    w_digit_nxt = 8'hFF;
    w_fnd_nxt   = SEG_OFF;
    if (!blank && !w_in_blank_win && w_show_mask[r_idx]) begin
      w_digit_nxt = ~(8'b1 << r_idx);
      w_fnd_nxt   = seg_polarity({w_dp_bit, seg_encode(w_nibble)});
    end
  end

  // Output registers; frame_done is registered one cycle early so it is high
  // exactly in the boundary cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit      <= 8'hFF;
      r_fnd        <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_digit      <= w_digit_nxt;
      r_fnd        <= w_fnd_nxt;
      r_frame_done <= w_pre_bnd;
    end
  end

  assign digit      = r_digit;
  assign fnd        = r_fnd;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver with SCAN_DIV=4, BLANK_CYC=1, SEG_ACTIVE_LOW=1.
// Table-driven words checked slot by slot through a scoreboard queue, plus
// hand sequences for reset, mid-frame loads, boundary loads, blanking and
// reset in mid-frame. Honours FND_LZB_EN when defined.
module tb_fnd_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic        data_valid = 1'b0;
  logic        blank = 1'b0;
  logic [7:0]  digit;
  logic [7:0]  fnd;
  logic        frame_done;

  always #5 clk = ~clk;

  fnd_scan_driver #(
    .SCAN_DIV      (4),
    .BLANK_CYC     (1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .data_valid(data_valid),
    .blank     (blank),
    .digit     (digit),
    .fnd       (fnd),
    .frame_done(frame_done)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] digit;
    logic [7:0] fnd;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic        bl;
    logic [7:0]  exp_fnd0;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected digit/fnd for each of the 8 slots of a frame showing this word.
  task automatic push_frame(input logic [31:0] d, input logic [7:0] dp, input logic bl);
    exp_t e;
    logic shown;
    for (int i = 0; i < 8; i++) begin
`ifdef FND_LZB_EN
      shown = (i == 0) || dp[i] || ((d >> (4 * i)) != 32'h0);
`else
      shown = 1'b1;
`endif
      if (bl || !shown) begin
        e.digit = 8'hFF;
        e.fnd   = 8'hFF;
      end else begin
        e.digit = ~(8'h01 << i);
        e.fnd   = ~{dp[i], seg_ref(d[4*i +: 4])};
      end
      sbq.push_back(e);
    end
  endtask

  // Advance to the next negedge at which frame_done is high; also drops data_valid.
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      data_valid = 1'b0;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_wait: got no frame_done expected pulse within 100 cycles");
    end
  endtask

  task automatic pulse(input logic [31:0] d, input logic [7:0] dp, input logic bl);
    data_in    = d;
    dp_in      = dp;
    blank      = bl;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Check every slot of the next frame against the scoreboard. Optionally
  // strobe a new word right after slot pulse_after has been checked.
  task automatic check_frame(input int pulse_after, input logic [31:0] pd,
                             input logic [7:0] pdp, output logic [7:0] fnd0);
    bit   ok;
    int   off;
    exp_t e;
    fnd0 = 8'hXX;
    wait_frame(ok);
    if (!ok) begin
      for (int k = 0; k < 8 && sbq.size() > 0; k++) void'(sbq.pop_front());
      return;
    end
    off = 0;
    for (int i = 0; i < 8; i++) begin
      while (off < 3 + 4 * i) begin
        @(negedge clk);
        off++;
        data_valid = 1'b0;
        if (off == 2) chk("blank_win_digit", digit, 8'hFF);
      end
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_empty: got empty queue expected entry for slot %0d", i);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("slot%0d_digit", i), digit, e.digit);
        chk($sformatf("slot%0d_fnd", i), fnd, e.fnd);
      end
      if (i == 0) fnd0 = fnd;
      if (i == pulse_after) begin
        data_in    = pd;
        dp_in      = pdp;
        data_valid = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    logic [7:0] f0;
    int         n;
    int         bad;

    tbl[0] = '{32'h89AB_CDEF, 8'h00, 1'b0, 8'h8E};
    tbl[1] = '{32'h0123_4567, 8'h55, 1'b0, 8'h78};
    tbl[2] = '{32'h0000_0000, 8'h01, 1'b1, 8'hFF};
    tbl[3] = '{32'h0000_0000, 8'h01, 1'b0, 8'h40};
    tbl[4] = '{32'h0000_0120, 8'h00, 1'b0, 8'hC0};
    tbl[5] = '{32'h0000_0120, 8'h80, 1'b0, 8'hC0};
    tbl[6] = '{32'hFFFF_FFFF, 8'hFF, 1'b0, 8'h0E};
    tbl[7] = '{32'h0000_000A, 8'h00, 1'b0, 8'h88};

    // Reset held 3 cycles, then release: one blank-window cycle, then '0'.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_digit", digit, 8'hFF);
    chk("rst_fnd", fnd, 8'hFF);
    chk("rst_frame_done", {7'b0, frame_done}, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("rel1_digit", digit, 8'hFF);
    chk("rel1_fnd", fnd, 8'hFF);
    @(negedge clk);
    chk("rel2_digit", digit, 8'hFE);
    chk("rel2_fnd", fnd, 8'hC0);

    // Table of words, each checked over a full frame.
    for (int i = 0; i < 8; i++) begin
      pulse(tbl[i].data, tbl[i].dp, tbl[i].bl);
      push_frame(tbl[i].data, tbl[i].dp, tbl[i].bl);
      check_frame(-1, 32'h0, 8'h0, f0);
      chk($sformatf("tbl%0d_fnd0", i), f0, tbl[i].exp_fnd0);
    end

    // Mid-frame strobe must not disturb the rest of the current frame.
    pulse(32'h1111_1111, 8'h00, 1'b0);
    push_frame(32'h1111_1111, 8'h00, 1'b0);
    check_frame(3, 32'h2222_2222, 8'h00, f0);
    push_frame(32'h2222_2222, 8'h00, 1'b0);
    check_frame(-1, 32'h0, 8'h0, f0);
    chk("midframe_next_fnd0", f0, 8'hA4);

    // Strobe on the boundary cycle wins over an older pending word.
    wait_frame(ok);
    repeat (5) @(negedge clk);
    data_in    = 32'h3333_3333;
    dp_in      = 8'h00;
    data_valid = 1'b1;
    wait_frame(ok);
    data_in    = 32'h0000_0001;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bnd_digit0", digit, 8'hFE);
    chk("bnd_fnd0", fnd, 8'hF9);
    push_frame(32'h0000_0001, 8'h00, 1'b0);
    check_frame(-1, 32'h0, 8'h0, f0);

    // Blank for a full frame: all dark, frame_done still every 32 cycles.
    pulse(32'h0, 8'h01, 1'b1);
    wait_frame(ok);
    n   = 0;
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n++;
      if (digit !== 8'hFF || fnd !== 8'hFF) bad++;
      if (frame_done) break;
    end
    chk("blank_period", 8'(n), 8'd32);
    chk("blank_dark_cycles_bad", 8'(bad), 8'd0);
    pulse(32'h0, 8'h01, 1'b0);
    push_frame(32'h0, 8'h01, 1'b0);
    check_frame(-1, 32'h0, 8'h0, f0);
    chk("unblank_fnd0", f0, 8'h40);

    // Reset while idx=5 with a word pending: dark at once, pending discarded.
    wait_frame(ok);
    repeat (10) @(negedge clk);
    data_in    = 32'h4444_4444;
    dp_in      = 8'h00;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_digit", digit, 8'hFF);
    chk("midrst_fnd", fnd, 8'hFF);
    chk("midrst_frame_done", {7'b0, frame_done}, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rel1_digit", digit, 8'hFF);
    @(negedge clk);
    chk("midrst_rel2_digit", digit, 8'hFE);
    chk("midrst_rel2_fnd", fnd, 8'hC0);
    push_frame(32'h0, 8'h00, 1'b0);
    check_frame(-1, 32'h0, 8'h0, f0);
    chk("midrst_next_fnd0", f0, 8'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
